// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration signals: active-low requests in, active-low grants plus owner/busy out.
// The slave modport is the arbiter's view; the master modport is the bus masters' view.
interface bus_arbiter_if;
  logic       m0_req_;
  logic       m1_req_;
  logic       m2_req_;
  logic       m3_req_;
  logic       m0_grnt_;
  logic       m1_grnt_;
  logic       m2_grnt_;
  logic       m3_grnt_;
  logic [1:0] owner;
  logic       busy;

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, busy
  );

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with registered active-low grants and an
// optional hold limit that forces a long-running owner to yield to waiting masters.
module bus_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input logic          clk,
  input logic          reset,
  bus_arbiter_if.slave bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t     r_state;
  logic [1:0] r_owner;
  logic [7:0] r_hold_cnt;
  logic [3:0] r_grnt_n;
  logic       r_busy;

  logic [3:0] w_req;
  logic [1:0] w_other_idx;
  logic       w_other_any;
  logic       w_owner_req;
  logic       w_hold_expired;

  assign w_req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
  assign w_owner_req = w_req[r_owner];

  // Search owner+1..owner+3 excluding the owner; descending loop lets the closest one win.
  always_comb begin
    w_other_idx = r_owner;
    w_other_any = 1'b0;
    for (int k = 3; k >= 1; k--) begin
      if (w_req[r_owner + 2'(k)]) begin
        w_other_idx = r_owner + 2'(k);
        w_other_any = 1'b1;
      end
    end
  end

  // hold_cnt >= HOLD_MAX-1, written without the subtraction so HOLD_MAX=0 cannot wrap.
  assign w_hold_expired = (HOLD_MAX != 0) && ((32'(r_hold_cnt) + 32'd1) >= HOLD_MAX);

  function automatic logic [3:0] grant_of(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_owner    <= 2'd3;
      r_hold_cnt <= 8'd0;
      r_grnt_n   <= 4'hF;
      r_busy     <= 1'b0;
    end else if (r_state == S_IDLE) begin
      // The owner itself is the last candidate when coming out of IDLE.
      if (w_other_any || w_owner_req) begin
        r_state    <= S_BUSY;
        r_owner    <= w_other_any ? w_other_idx : r_owner;
        r_grnt_n   <= grant_of(w_other_any ? w_other_idx : r_owner);
        r_busy     <= 1'b1;
        r_hold_cnt <= 8'd0;
      end
    end else begin
      if (w_owner_req && !(w_hold_expired && w_other_any)) begin
        if (r_hold_cnt != 8'hFF) begin
          r_hold_cnt <= r_hold_cnt + 8'd1;
        end
      end else if (w_other_any) begin
        // Release or forced handover: move straight to the next master, no idle gap.
        r_owner    <= w_other_idx;
        r_grnt_n   <= grant_of(w_other_idx);
        r_hold_cnt <= 8'd0;
      end else begin
        r_state    <= S_IDLE;
        r_grnt_n   <= 4'hF;
        r_busy     <= 1'b0;
        r_hold_cnt <= 8'd0;
      end
    end
  end

  assign bus.m0_grnt_ = r_grnt_n[0];
  assign bus.m1_grnt_ = r_grnt_n[1];
  assign bus.m2_grnt_ = r_grnt_n[2];
  assign bus.m3_grnt_ = r_grnt_n[3];
  assign bus.owner    = r_owner;
  assign bus.busy     = r_busy;

endmodule
